// File: rtl/contador_monitor_if.sv
// contador_monitor_if: sample/result bundle between a counter stream source and
// the sequence monitor.
//   master : drives valid/modo/q, observes locked/erro/err_count/last_q
//   slave  : the monitor itself (consumes the sample, produces the status)
interface contador_monitor_if;
  localparam int unsigned QW   = 4;
  localparam int unsigned RW   = 3;
  localparam int unsigned CNTW = 8;

  logic            valid;
  logic            modo;
  logic [QW-1:0]   q;
  logic            locked;
  logic            erro;
  logic [CNTW-1:0] err_count;
  logic [RW-1:0]   last_q;

  modport master (
    output valid, modo, q,
    input  locked, erro, err_count, last_q
  );

  modport slave (
    input  valid, modo, q,
    output locked, erro, err_count, last_q
  );
endinterface

// File: rtl/contador_monitor.sv
// contador_monitor: checks that a 3-bit up/down counter stream steps by exactly
// one (mod 8) in the direction given with each sample.
// Ports:
//   clock : rising-edge system clock
//   reset : synchronous, active-low
//   mon   : contador_monitor_if.slave
//           valid/modo/q in; locked/erro/err_count/last_q out (all registered)
// Optional feature: define CONTADOR_MONITOR_RANGE_CHECK_EN to treat q>7 as a
// mismatch in every state, including the seeding sample in IDLE.
module contador_monitor (
  input  logic              clock,
  input  logic              reset,
  contador_monitor_if.slave mon
);
  localparam int unsigned RW   = 3;
  localparam int unsigned CNTW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    FAULT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   ref_q, ref_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            erro_q, erro_d;
  logic            locked_q, locked_d;

  logic [RW-1:0]   sample_c;
  logic [RW-1:0]   expected_c;
  logic            range_bad_c;
  logic            mismatch_c;

  // Expected next value with natural 3-bit wrap (7->0 up, 0->7 down).
  assign sample_c   = mon.q[RW-1:0];
  assign expected_c = mon.modo ? RW'(ref_q + RW'(1)) : RW'(ref_q - RW'(1));

`ifdef CONTADOR_MONITOR_RANGE_CHECK_EN
  assign range_bad_c = mon.q[3];
`else
  // Top bit of q is deliberately ignored in this build.
  logic unused_q3_c;
  assign unused_q3_c = mon.q[3];
  assign range_bad_c = 1'b0;
`endif

  assign mismatch_c = range_bad_c || (sample_c != expected_c);

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      ref_q    <= '0;
      cnt_q    <= '0;
      erro_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      erro_q   <= erro_d;
      locked_q <= locked_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (mon.valid) begin
      case (state_q)
        IDLE:        state_d = range_bad_c ? FAULT : LOCK;
        LOCK, FAULT: state_d = mismatch_c ? FAULT : LOCK;
        default:     state_d = IDLE;
      endcase
    end
  end

  // Output next values; the seeding sample in IDLE is only judged on range.
  always_comb begin
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    erro_d   = 1'b0;
    locked_d = (state_d == LOCK);
    if (mon.valid) begin
      ref_d  = sample_c;
      erro_d = (state_q == IDLE) ? range_bad_c : mismatch_c;
      if (erro_d && (cnt_q != '1)) begin
        cnt_d = CNTW'(cnt_q + CNTW'(1));
      end
    end
  end

  assign mon.locked    = locked_q;
  assign mon.erro      = erro_q;
  assign mon.err_count = cnt_q;
  assign mon.last_q    = ref_q;
endmodule
